z80_bus_responder: RTL and testbench
====================================

// Module: z80_bus_responder
// PURPOSE
//  Target side of the tv80s external bus: decodes M1/MREQ/IORQ/RD/WR/RFSH, serves
//  memory and 256-byte I/O space, answers interrupt-acknowledge with a vector, and
//  stretches cycles via WAIT_n. Sits between tv80s (A/dout/strobes) and its di port;
//  replaces the behavioural negedge memory model with a posedge-only synthesizable target.
// PARAMETERS
//  MEM_AW    16  memory address width; A[MEM_AW-1:0] used, upper bits ignored (alias)
//  MEM_WAIT  0   wait states inserted on memory read/write cycles (0..15)
//  IO_WAIT   1   wait states inserted on I/O read/write and INTA cycles (0..15)
// PORTS
//  clk        in   1   CPU clock, all logic on rising edge
//  reset_n    in   1   asynchronous active-low reset
//  A          in   16  CPU address bus
//  cpu_do     in   8   CPU write data
//  m1_n       in   1   opcode fetch / INTA qualifier
//  mreq_n     in   1   memory request
//  iorq_n     in   1   I/O request
//  rd_n       in   1   read strobe
//  wr_n       in   1   write strobe
//  rfsh_n     in   1   refresh qualifier
//  int_vec    in   8   vector returned on INTA (M1 & IORQ)
//  cpu_di     out  8   read data to CPU
//  wait_n     out  1   wait request to CPU, low = stretch
//  wr_mon     out  1   one-cycle pulse per committed write
//  wr_mon_io  out  1   committed write targets I/O space
//  wr_mon_a   out  16  committed write address (I/O: {8'h10,A[7:0]})
//  wr_mon_d   out  8   committed write data
// BEHAVIOUR
//  Reset: state IDLE, cpu_di=8'h00, wait_n=1, wr_mon=0, wr_mon_io=0, wr_mon_a=0,
//   wr_mon_d=0, wait counter=0. Array contents are not reset.
//  Cycle decode (sampled at posedge, IDLE only):
//   MEMRD  mreq_n=0 & rd_n=0 & rfsh_n=1;  MEMWR mreq_n=0 & wr_n=0
//   IORD   iorq_n=0 & rd_n=0 & m1_n=1;    IOWR  iorq_n=0 & wr_n=0
//   INTA   iorq_n=0 & m1_n=0 (priority over IORD)
//   mreq_n=0 & rfsh_n=0 (refresh) is ignored: no read, no write, no wait.
//  FSM: IDLE -> WAIT (if wait count>0) | DATA; WAIT -> DATA when counter reaches 0;
//   DATA -> HOLD; HOLD -> IDLE when mreq_n & iorq_n & rd_n & wr_n all high.
//  On decode: latch A, cpu_do and kind; load counter with MEM_WAIT or IO_WAIT.
//   wait_n registered low from the cycle after decode while counter>0, else high.
//  DATA: read kinds register cpu_di (MEMRD: mem[A], IORD: io[A[7:0]],
//   INTA: int_vec); cpu_di holds until the next DATA. Write kinds commit exactly once
//   per bus cycle, in DATA, from the latched address/data; wr_mon pulses then.
//  Read latency with 0 waits: cpu_di valid 2 posedges after strobe sampled low.
//  Strobes released early (in WAIT): abort to IDLE, no commit, wait_n=1 next cycle.
//  Strobes still low in HOLD: no re-decode, no second commit (one access per cycle).
//  Address wrap: memory index A[MEM_AW-1:0]; I/O index A[7:0]; A[15:8] ignored for I/O.
//  Async reset mid-cycle: immediate return to IDLE, wait_n=1, pending write dropped.
// STRUCTURE
//  Package z80_bus_pkg: typedef enum {IDLE,WAIT,DATA,HOLD} zbus_state_t;
//   typedef enum {K_MEMRD,K_MEMWR,K_IORD,K_IOWR,K_INTA} zbus_kind_t; IO_MON_BASE=8'h10.
//  Sub-module z80_bus_ram: single-port sync RAM (depth 2**AW, 1-cycle read),
//   instantiated twice: memory (AW=MEM_AW) and I/O (AW=8). FSM and counter in top.
// TESTING
//  1 Preload mem[16'h0000..3]=dd cb 8a ca, mem[a811]=7e; run tv80s DD CB 8A CA
//    (SET 1,(IX+8Ah)->D, IX=a887) -> mem[a811]=7e, D=7e, PC=0004, one wr_mon at a811.
//  2 MEM_WAIT=3, LD A,(1234h) with mem[1234]=5a -> wait_n low exactly 3 cycles
//    per memory cycle, A=5a, no extra writes.
//  3 OUT (42h),A with A=99 -> wr_mon=1 once, wr_mon_io=1, wr_mon_a=1042,
//    io[42]=99; IN A,(42h) -> A=99.
//  4 Refresh strobes with A=0000 -> cpu_di unchanged, wait_n=1, no wr_mon.
//  5 IM2, int_vec=e0 forced on INTA -> cpu_di=e0 in INTA DATA, IO_WAIT waits applied.
//  6 Assert reset_n=0 during WAIT of an MEMWR to 2000 -> wait_n=1 at once,
//    mem[2000] unchanged, state IDLE after release.

Source files
------------

// File: rtl/z80_bus_pkg.sv
// Shared types for the Z80 bus responder.
//   zbus_state_t : bus-cycle FSM states
//   zbus_kind_t  : decoded bus-cycle kind
//   IO_MON_BASE  : upper byte reported on wr_mon_a for I/O writes
package z80_bus_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, DATA, HOLD} zbus_state_t;

   typedef enum logic [2:0] {K_MEMRD, K_MEMWR, K_IORD, K_IOWR, K_INTA} zbus_kind_t;

   localparam logic [7:0] IO_MON_BASE = 8'h10;

   function automatic logic is_mem_kind(zbus_kind_t k);
      return (k == K_MEMRD) || (k == K_MEMWR);
   endfunction

endpackage

// File: rtl/z80_bus_ram.sv
// Single-port synchronous RAM, 8-bit wide, depth 2**AW.
// Read data is registered: rdata shows mem[addr] one clock after addr is presented.
// A write and a read to the same address in one cycle returns the old contents.
//   clk   in  clock
//   we    in  write enable
//   addr  in  AW-bit address
//   wdata in  write data
//   rdata out registered read data
module z80_bus_ram #(
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);

   logic [7:0] mem_q [2**AW];
   logic [7:0] rdata_q;

   // Contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
      rdata_q <= mem_q[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/z80_bus_responder.sv
// Target side of the tv80s external bus. Decodes memory read/write, I/O read/write
// and interrupt acknowledge, serves a memory array and a 256-byte I/O array, returns
// int_vec on INTA and stretches cycles with wait_n.
//   clk, reset_n        clock, asynchronous active-low reset
//   A, cpu_do           CPU address and write data
//   m1_n .. rfsh_n      CPU bus strobes (active low)
//   int_vec             vector returned on INTA
//   cpu_di              registered read data to the CPU
//   wait_n              registered wait request (low = stretch)
//   wr_mon*             one-cycle pulse plus address/data of each committed write
//   state_dbg           current FSM state (zbus_state_t encoding)
//
// Handshake: a bus cycle is accepted only in IDLE when a strobe combination decodes.
// The cycle then runs WAIT (wait_n low) for the configured number of clocks, one DATA
// clock in which the read is captured or the write is committed, and HOLD until the
// CPU releases every strobe. Releasing all strobes during WAIT abandons the cycle.
module z80_bus_responder
   import z80_bus_pkg::*;
#(
   parameter int MEM_AW   = 16,
   parameter int MEM_WAIT = 0,
   parameter int IO_WAIT  = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] A,
   input  logic [7:0]  cpu_do,
   input  logic        m1_n,
   input  logic        mreq_n,
   input  logic        iorq_n,
   input  logic        rd_n,
   input  logic        wr_n,
   input  logic        rfsh_n,
   input  logic [7:0]  int_vec,
   output logic [7:0]  cpu_di,
   output logic        wait_n,
   output logic        wr_mon,
   output logic        wr_mon_io,
   output logic [15:0] wr_mon_a,
   output logic [7:0]  wr_mon_d,
   output logic [1:0]  state_dbg
);

   zbus_state_t state_q, state_d;
   zbus_kind_t  kind_q, kind_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  data_q, data_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  cpu_di_q, cpu_di_d;
   logic        wait_n_q, wait_n_d;
   logic        mon_pulse_q, mon_pulse_d;
   logic        mon_io_q, mon_io_d;
   logic [15:0] mon_a_q, mon_a_d;
   logic [7:0]  mon_dat_q, mon_dat_d;

   logic        dec_valid;
   zbus_kind_t  dec_kind;
   logic [3:0]  dec_wait;
   logic        bus_idle;

   logic [15:0] ram_addr;
   logic        mem_we, io_we;
   logic [7:0]  mem_rdata, io_rdata;

   // Strobe decode. Refresh (mreq_n & rfsh_n low) never matches a memory kind.
   always_comb begin
      dec_valid = 1'b1;
      dec_kind  = K_MEMRD;
      if (!mreq_n && rfsh_n && !rd_n) begin
         dec_kind = K_MEMRD;
      end else if (!mreq_n && rfsh_n && !wr_n) begin
         dec_kind = K_MEMWR;
      end else if (!iorq_n && !m1_n) begin
         dec_kind = K_INTA;
      end else if (!iorq_n && !rd_n) begin
         dec_kind = K_IORD;
      end else if (!iorq_n && !wr_n) begin
         dec_kind = K_IOWR;
      end else begin
         dec_valid = 1'b0;
      end
      dec_wait = is_mem_kind(dec_kind) ? 4'(MEM_WAIT) : 4'(IO_WAIT);
   end

   assign bus_idle = mreq_n && iorq_n && rd_n && wr_n;

   // State register and all datapath flops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         kind_q      <= K_MEMRD;
         addr_q      <= 16'h0000;
         data_q      <= 8'h00;
         cnt_q       <= 4'd0;
         cpu_di_q    <= 8'h00;
         wait_n_q    <= 1'b1;
         mon_pulse_q <= 1'b0;
         mon_io_q    <= 1'b0;
         mon_a_q     <= 16'h0000;
         mon_dat_q   <= 8'h00;
      end else begin
         state_q     <= state_d;
         kind_q      <= kind_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         cnt_q       <= cnt_d;
         cpu_di_q    <= cpu_di_d;
         wait_n_q    <= wait_n_d;
         mon_pulse_q <= mon_pulse_d;
         mon_io_q    <= mon_io_d;
         mon_a_q     <= mon_a_d;
         mon_dat_q   <= mon_dat_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      kind_d  = kind_q;
      addr_d  = addr_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (dec_valid) begin
               kind_d  = dec_kind;
               addr_d  = A;
               data_d  = cpu_do;
               cnt_d   = dec_wait;
               state_d = (dec_wait != 4'd0) ? WAIT : DATA;
            end
         end
         WAIT: begin
            if (bus_idle) begin
               // CPU gave up on the cycle: nothing is read or written.
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d = DATA;
               end
            end
         end
         DATA: state_d = HOLD;
         HOLD: begin
            if (bus_idle) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output / datapath logic.
   always_comb begin
      // wait_n follows the state being entered so it is low exactly while in WAIT.
      wait_n_d    = (state_d != WAIT);
      cpu_di_d    = cpu_di_q;
      mon_pulse_d = 1'b0;
      mon_io_d    = mon_io_q;
      mon_a_d     = mon_a_q;
      mon_dat_d   = mon_dat_q;
      mem_we      = 1'b0;
      io_we       = 1'b0;
      // In IDLE the RAMs read the live bus address so read data is ready by DATA
      // even with zero wait states; afterwards they see the latched address.
      ram_addr    = (state_q == IDLE) ? A : addr_q;
      if (state_q == DATA) begin
         case (kind_q)
            K_MEMRD: cpu_di_d = mem_rdata;
            K_IORD:  cpu_di_d = io_rdata;
            K_INTA:  cpu_di_d = int_vec;
            K_MEMWR: begin
               mem_we      = 1'b1;
               mon_pulse_d = 1'b1;
               mon_io_d    = 1'b0;
               mon_a_d     = addr_q;
               mon_dat_d   = data_q;
            end
            K_IOWR: begin
               io_we       = 1'b1;
               mon_pulse_d = 1'b1;
               mon_io_d    = 1'b1;
               mon_a_d     = {IO_MON_BASE, addr_q[7:0]};
               mon_dat_d   = data_q;
            end
            default: cpu_di_d = cpu_di_q;
         endcase
      end
   end

   z80_bus_ram #(.AW(MEM_AW)) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .addr  (ram_addr[MEM_AW-1:0]),
      .wdata (data_q),
      .rdata (mem_rdata)
   );

   z80_bus_ram #(.AW(8)) u_io (
      .clk   (clk),
      .we    (io_we),
      .addr  (ram_addr[7:0]),
      .wdata (data_q),
      .rdata (io_rdata)
   );

   assign cpu_di    = cpu_di_q;
   assign wait_n    = wait_n_q;
   assign wr_mon    = mon_pulse_q;
   assign wr_mon_io = mon_io_q;
   assign wr_mon_a  = mon_a_q;
   assign wr_mon_d  = mon_dat_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_z80_bus_responder.sv
// Bench for z80_bus_responder: directed bus cycles followed by a randomized mix,
// checked against a transaction-level model of the memory/I/O spaces and the
// expected wait/commit timing of each bus cycle.
module tb_z80_bus_responder;

   localparam int MEM_AW   = 12;
   localparam int MEM_WAIT = 3;
   localparam int IO_WAIT  = 1;

   localparam int B_NONE  = -1;
   localparam int B_MEMRD = 0;
   localparam int B_MEMWR = 1;
   localparam int B_IORD  = 2;
   localparam int B_IOWR  = 3;
   localparam int B_INTA  = 4;
   localparam int B_RFSH  = 5;

   // clock / reset
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] A = 16'h0000;
   logic [7:0]  cpu_do = 8'h00;
   logic        m1_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1;
   logic        rd_n = 1'b1, wr_n = 1'b1, rfsh_n = 1'b1;
   logic [7:0]  int_vec = 8'h00;
   logic [7:0]  cpu_di;
   logic        wait_n, wr_mon, wr_mon_io;
   logic [15:0] wr_mon_a;
   logic [7:0]  wr_mon_d;
   logic [1:0]  state_dbg;

   z80_bus_responder #(.MEM_AW(MEM_AW), .MEM_WAIT(MEM_WAIT), .IO_WAIT(IO_WAIT)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .A         (A),
      .cpu_do    (cpu_do),
      .m1_n      (m1_n),
      .mreq_n    (mreq_n),
      .iorq_n    (iorq_n),
      .rd_n      (rd_n),
      .wr_n      (wr_n),
      .rfsh_n    (rfsh_n),
      .int_vec   (int_vec),
      .cpu_di    (cpu_di),
      .wait_n    (wait_n),
      .wr_mon    (wr_mon),
      .wr_mon_io (wr_mon_io),
      .wr_mon_a  (wr_mon_a),
      .wr_mon_d  (wr_mon_d),
      .state_dbg (state_dbg)
   );

   // reference model
   logic [7:0]  mem_m [2**MEM_AW];
   logic [7:0]  io_m  [256];
   logic [11:0] mem_list[$];
   logic [7:0]  io_list[$];
   logic [7:0]  last_di = 8'h00;

   // scoreboard: {io, addr[15:0], data[7:0]} of each expected commit
   logic [24:0] exp_q[$];
   logic [24:0] exp_w;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Every committed write must match the oldest expected one.
   always @(negedge clk) begin
      if (reset_n && wr_mon) begin
         if (exp_q.size() == 0) begin
            chk("wr_spurious", {31'b0, wr_mon}, 32'd0);
         end else begin
            exp_w = exp_q.pop_front();
            chk("wr_mon_io", {31'b0, wr_mon_io}, {31'b0, exp_w[24]});
            chk("wr_mon_a", {16'b0, wr_mon_a}, {16'b0, exp_w[23:8]});
            chk("wr_mon_d", {24'b0, wr_mon_d}, {24'b0, exp_w[7:0]});
         end
      end
   end

   // driver tasks
   task automatic drive(input int k, input logic [15:0] a, input logic [7:0] d);
      A = a;
      cpu_do = d;
      m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1;
      rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
      case (k)
         B_MEMRD: begin mreq_n = 1'b0; rd_n = 1'b0; end
         B_MEMWR: begin mreq_n = 1'b0; wr_n = 1'b0; end
         B_IORD:  begin iorq_n = 1'b0; rd_n = 1'b0; end
         B_IOWR:  begin iorq_n = 1'b0; wr_n = 1'b0; end
         B_INTA:  begin iorq_n = 1'b0; m1_n = 1'b0; end
         B_RFSH:  begin mreq_n = 1'b0; rfsh_n = 1'b0; end
         default: ;
      endcase
   endtask

   // One complete bus cycle: strobes held for waits+4 clocks, then released.
   // Expected: wait_n low on the first `w` clocks after the sampling edge, data
   // (read) or the commit pulse (write) visible on clock w+2, nothing afterwards.
   task automatic bus_cycle(input int k, input logic [15:0] a, input logic [7:0] d);
      int          w;
      logic [15:0] wait_obs, mon_obs, wait_exp, mon_exp;
      logic [7:0]  di_exp, di_before, di_at;
      bit          is_wr;
      w = (k == B_MEMRD || k == B_MEMWR) ? MEM_WAIT : ((k == B_RFSH) ? 0 : IO_WAIT);
      is_wr = (k == B_MEMWR || k == B_IOWR);
      di_exp = last_di;
      case (k)
         B_MEMRD: di_exp = mem_m[a[MEM_AW-1:0]];
         B_IORD:  di_exp = io_m[a[7:0]];
         B_INTA:  di_exp = int_vec;
         B_MEMWR: begin
            mem_m[a[MEM_AW-1:0]] = d;
            mem_list.push_back(a[MEM_AW-1:0]);
            exp_q.push_back({1'b0, a, d});
         end
         B_IOWR: begin
            io_m[a[7:0]] = d;
            io_list.push_back(a[7:0]);
            exp_q.push_back({1'b1, 8'h10, a[7:0], d});
         end
         default: ;
      endcase
      wait_exp = 16'(((1 << w) - 1) << 1);
      mon_exp  = is_wr ? 16'(1 << (w + 2)) : 16'h0000;
      wait_obs = 16'h0000;
      mon_obs  = 16'h0000;
      di_before = 8'h00;
      di_at = 8'h00;
      @(negedge clk);
      drive(k, a, d);
      for (int i = 1; i <= w + 4; i++) begin
         @(negedge clk);
         wait_obs[i] = ~wait_n;
         mon_obs[i]  = wr_mon;
         if (i == w + 1) di_before = cpu_di;
         if (i == w + 2) di_at = cpu_di;
      end
      drive(B_NONE, a, d);
      @(negedge clk);
      @(negedge clk);
      chk("wait_mask", {16'b0, wait_obs}, {16'b0, wait_exp});
      chk("commit_mask", {16'b0, mon_obs}, {16'b0, mon_exp});
      chk("cpu_di_before", {24'b0, di_before}, {24'b0, last_di});
      chk("cpu_di", {24'b0, di_at}, {24'b0, di_exp});
      chk("idle_after", {30'b0, state_dbg}, 32'd0);
      last_di = di_exp;
   endtask

   initial begin
      int k;
      logic [15:0] a;
      logic [7:0]  d;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_cpu_di", {24'b0, cpu_di}, 32'h00);
      chk("rst_wait_n", {31'b0, wait_n}, 32'd1);
      chk("rst_wr_mon", {31'b0, wr_mon}, 32'd0);
      chk("rst_wr_mon_io", {31'b0, wr_mon_io}, 32'd0);
      chk("rst_wr_mon_a", {16'b0, wr_mon_a}, 32'h0);
      chk("rst_wr_mon_d", {24'b0, wr_mon_d}, 32'h0);
      chk("rst_state", {30'b0, state_dbg}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // directed cycles
      bus_cycle(B_IOWR, 16'h0042, 8'h99);
      bus_cycle(B_IORD, 16'h3442, 8'h00);   // upper address byte ignored for I/O
      bus_cycle(B_MEMWR, 16'h1234, 8'h5a);
      bus_cycle(B_MEMRD, 16'h1234, 8'h00);
      bus_cycle(B_MEMRD, 16'hf234, 8'h00);  // aliases to the same memory location
      bus_cycle(B_RFSH, 16'h0000, 8'h00);   // refresh: no wait, no data, no write
      int_vec = 8'he0;
      bus_cycle(B_INTA, 16'h00ff, 8'h00);
      bus_cycle(B_MEMWR, 16'h2000, 8'h11);

      // randomized mix
      for (int n = 0; n < 80; n++) begin
         k = $urandom_range(0, 5);
         a = 16'($urandom);
         d = 8'($urandom);
         if (k == B_MEMRD) begin
            a = {4'($urandom_range(0, 15)), mem_list[$urandom_range(0, mem_list.size() - 1)]};
         end else if (k == B_IORD) begin
            a = {8'($urandom), io_list[$urandom_range(0, io_list.size() - 1)]};
         end else if (k == B_INTA) begin
            int_vec = 8'($urandom);
         end
         bus_cycle(k, a, d);
      end

      // restore a known value at 0x2000 (index 0x000) for the abort cases
      bus_cycle(B_MEMWR, 16'h2000, 8'h11);

      // strobes released during WAIT: cycle abandoned, nothing written
      @(negedge clk);
      drive(B_MEMWR, 16'h2000, 8'hee);
      @(negedge clk);
      chk("abort_wait_low", {31'b0, wait_n}, 32'd0);
      chk("abort_in_wait", {30'b0, state_dbg}, 32'd1);
      drive(B_NONE, 16'h2000, 8'hee);
      @(negedge clk);
      chk("abort_wait_high", {31'b0, wait_n}, 32'd1);
      chk("abort_idle", {30'b0, state_dbg}, 32'd0);
      repeat (4) @(negedge clk);
      bus_cycle(B_MEMRD, 16'h2000, 8'h00);

      // asynchronous reset during WAIT of a memory write
      @(negedge clk);
      drive(B_MEMWR, 16'h2000, 8'h77);
      @(negedge clk);
      chk("rstw_wait_low", {31'b0, wait_n}, 32'd0);
      #1 reset_n = 1'b0;
      #1;
      chk("rstw_wait_n", {31'b0, wait_n}, 32'd1);
      chk("rstw_state", {30'b0, state_dbg}, 32'd0);
      chk("rstw_cpu_di", {24'b0, cpu_di}, 32'h00);
      last_di = 8'h00;
      @(negedge clk);
      drive(B_NONE, 16'h2000, 8'h77);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("rstw_idle", {30'b0, state_dbg}, 32'd0);
      bus_cycle(B_MEMRD, 16'h2000, 8'h00);

      chk("commits_outstanding", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
